// File: rtl/aes_key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_schedule_ctrl
// Purpose  : Iterative AES-128/192/256 key-schedule engine. Loads the cipher
//            key, expands it one 32-bit word per cycle into an internal word
//            buffer, then serves 128-bit round keys over a registered
//            request/valid read port.
// Ports    : clk      - system clock (rising edge)
//            rst      - asynchronous active-low reset
//            start    - begin a new expansion (honoured in IDLE / READY)
//            key_size - 0:128, 1:192, 2:256, 3:illegal
//            key_in   - left-aligned cipher key (word 0 in the MSBs)
//            busy     - expansion in progress (LOAD / EXPAND)
//            done     - one-cycle pulse when the schedule is complete
//            ready    - schedule valid and readable
//            nr       - round count of stored schedule, 0 when not ready
//            err      - one-cycle pulse on illegal start or illegal read
//            rk_req   - round-key read request
//            rk_idx   - round-key index 0..nr
//            rk_valid - read response valid
//            rk_data  - round key {w[4k], w[4k+1], w[4k+2], w[4k+3]}
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_schedule_ctrl #(
  parameter int MAX_NK    = 8,
  parameter int NB        = 4,
  parameter int MAX_WORDS = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            key_size,
  input  logic [32*MAX_NK-1:0]  key_in,
  output logic                  busy,
  output logic                  done,
  output logic                  ready,
  output logic [3:0]            nr,
  output logic                  err,
  input  logic                  rk_req,
  input  logic [3:0]            rk_idx,
  output logic                  rk_valid,
  output logic [127:0]          rk_data
);

  localparam int AW = $clog2(MAX_WORDS);

  // AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_EXPAND = 2'd2,
    S_READY  = 2'd3
  } state_t;

  state_t            state;
  logic [3:0]        nk_r;       // key length in words of the run in progress
  logic [3:0]        nr_tgt;     // round count of the run in progress
  logic [AW-1:0]     last_idx;   // index of the final schedule word
  logic [AW-1:0]     widx;       // next word to be written
  logic [2:0]        kpos;       // widx mod nk, tracked incrementally
  logic [7:0]        rcon;
  logic [31:0]       prev_word;  // w[widx-1], kept locally to avoid a buffer read port

  logic [31:0]       sched [MAX_WORDS];

  logic [31:0]       w_back;
  logic [31:0]       temp;
  logic [31:0]       new_word;
  logic [31:0]       key_last;
  logic [AW-1:0]     rd_base;
  logic [32*NB-1:0]  rd_key;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[(255 - int'(b))*8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Next schedule word.
  always_comb begin
    w_back = sched[widx - AW'(nk_r)];
    temp   = prev_word;
    if (kpos == 3'd0)
      temp = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h0};
    else if (nk_r == 4'd8 && kpos == 3'd4)
      temp = sub_word(prev_word);
    new_word = w_back ^ temp;
  end

  // Last key word (w[NK-1]) seeds prev_word when expansion begins.
  always_comb begin
    key_last = key_in[32*MAX_NK-1 -: 32];
    for (int j = 0; j < MAX_NK; j++) begin
      if (4'(j) + 4'd1 == nk_r)
        key_last = key_in[32*(MAX_NK-j)-1 -: 32];
    end
  end

  // Round-key gather for the read port.
  always_comb begin
    rd_base = AW'(rk_idx) * AW'(NB);
    rd_key  = '0;
    for (int j = 0; j < NB; j++)
      rd_key[32*(NB-j)-1 -: 32] = sched[rd_base + AW'(j)];
  end

  // Schedule buffer: not reset, only readable once ready is set.
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      for (int j = 0; j < MAX_NK; j++) begin
        if (4'(j) < nk_r)
          sched[j] <= key_in[32*(MAX_NK-j)-1 -: 32];
      end
    end else if (state == S_EXPAND) begin
      sched[widx] <= new_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ready     <= 1'b0;
      nr        <= 4'd0;
      err       <= 1'b0;
      rk_valid  <= 1'b0;
      rk_data   <= '0;
      nk_r      <= 4'd4;
      nr_tgt    <= 4'd0;
      last_idx  <= '0;
      widx      <= '0;
      kpos      <= 3'd0;
      rcon      <= 8'h01;
      prev_word <= 32'h0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rk_valid <= 1'b0;

      // Read port uses the current (old) schedule even if a restart is
      // accepted on the same edge.
      if (ready && rk_req) begin
        if (rk_idx <= nr) begin
          rk_valid <= 1'b1;
          rk_data  <= rd_key[127:0];
        end else begin
          err <= 1'b1;
        end
      end

      case (state)
        S_IDLE, S_READY: begin
          if (start) begin
            if (key_size == 2'd3) begin
              err <= 1'b1;
            end else begin
              case (key_size)
                2'd0:    begin nk_r <= 4'd4; nr_tgt <= 4'd10; last_idx <= AW'(43); end
                2'd1:    begin nk_r <= 4'd6; nr_tgt <= 4'd12; last_idx <= AW'(51); end
                default: begin nk_r <= 4'd8; nr_tgt <= 4'd14; last_idx <= AW'(59); end
              endcase
              state <= S_LOAD;
              busy  <= 1'b1;
              ready <= 1'b0;
              nr    <= 4'd0;
              rcon  <= 8'h01;
            end
          end
        end

        S_LOAD: begin
          widx      <= AW'(nk_r);
          kpos      <= 3'd0;
          prev_word <= key_last;
          state     <= S_EXPAND;
        end

        S_EXPAND: begin
          prev_word <= new_word;
          widx      <= widx + AW'(1);
          kpos      <= (4'(kpos) == nk_r - 4'd1) ? 3'd0 : kpos + 3'd1;
          if (kpos == 3'd0)
            rcon <= xtime(rcon);
          if (widx == last_idx) begin
            state <= S_READY;
            busy  <= 1'b0;
            done  <= 1'b1;
            ready <= 1'b1;
            nr    <= nr_tgt;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_schedule_ctrl
// Purpose  : Directed self-checking bench for aes_key_schedule_ctrl using
//            FIPS-197 key-expansion vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_schedule_ctrl;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   key_size;
  logic [255:0] key_in;
  logic         busy, done, ready, err, rk_valid;
  logic [3:0]   nr;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;

  int tests = 0;
  int fails = 0;
  bit seen_done;

  always #5 clk = ~clk;

  aes_key_schedule_ctrl #(.MAX_NK(8), .NB(4), .MAX_WORDS(60)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_size (key_size),
    .key_in   (key_in),
    .busy     (busy),
    .done     (done),
    .ready    (ready),
    .nr       (nr),
    .err      (err),
    .rk_req   (rk_req),
    .rk_idx   (rk_idx),
    .rk_valid (rk_valid),
    .rk_data  (rk_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a start; the edge inside this task is the sampling edge.
  task automatic begin_run(input logic [1:0] ks, input logic [255:0] key);
    key_size = ks;
    key_in   = key;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready_low", ready, 0);
    chk("start_nr_zero", nr, 0);
  endtask

  // Wait for done (bounded); optionally inject a start + read while busy.
  task automatic wait_done(input string tag, input int exp_lat, input bit inject);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      tick();
      n++;
      if (inject && n == 5) begin
        start    = 1'b1;
        key_size = 2'd0;
        key_in   = K128;
        rk_req   = 1'b1;
        rk_idx   = 4'd0;
      end else if (inject && n == 6) begin
        start  = 1'b0;
        rk_req = 1'b0;
        chk("busy_read_no_valid", rk_valid, 0);
        chk("busy_read_no_err", err, 0);
        chk("busy_start_still_busy", busy, 1);
      end
      if (done) seen = 1'b1;
    end
    chk(tag, n, exp_lat);
  endtask

  task automatic rd(input string tag, input logic [3:0] idx, input bit exp_valid,
                    input logic [127:0] exp_data, input bit exp_err);
    rk_req = 1'b1;
    rk_idx = idx;
    tick();
    rk_req = 1'b0;
    chk({tag, "_valid"}, rk_valid, exp_valid);
    if (exp_valid) chk({tag, "_data"}, rk_data, exp_data);
    chk({tag, "_err"}, err, exp_err);
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    key_size = 2'd0;
    key_in   = '0;
    rk_req   = 1'b0;
    rk_idx   = 4'd0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ready, 0);
    chk("rst_nr", nr, 0);
    chk("rst_err", err, 0);
    chk("rst_rk_valid", rk_valid, 0);
    chk("rst_rk_data", rk_data, 0);
    rst = 1'b1;
    tick();

    // Read while not ready: no response, no error.
    rd("idle_read", 4'd0, 1'b0, 128'h0, 1'b0);

    // AES-128.
    begin_run(2'd0, K128);
    wait_done("lat128", 41, 1'b0);
    chk("a128_ready", ready, 1);
    chk("a128_nr", nr, 10);
    chk("a128_busy", busy, 0);
    tick();
    chk("a128_done_pulse", done, 0);
    chk("a128_ready_level", ready, 1);
    rd("a128_rk0", 4'd0, 1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    rd("a128_rk1", 4'd1, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0);
    rd("a128_rk2", 4'd2, 1'b1, 128'hf2c295f27a96b9435935807a7359f67f, 1'b0);
    rd("a128_rk10", 4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0);

    // Illegal start while READY.
    key_size = 2'd3;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    chk("ill_start_err", err, 1);
    chk("ill_start_ready", ready, 1);
    chk("ill_start_busy", busy, 0);
    chk("ill_start_nr", nr, 10);
    tick();
    chk("ill_start_err_pulse", err, 0);
    rd("ill_rk10", 4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0);
    rd("ill_rk11", 4'd11, 1'b0, 128'h0, 1'b1);
    tick();
    chk("ill_rk11_err_pulse", err, 0);

    // AES-192 with start and read injected while busy.
    begin_run(2'd1, K192);
    wait_done("lat192", 47, 1'b1);
    chk("a192_nr", nr, 12);
    rd("a192_rk1", 4'd1, 1'b1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5, 1'b0);
    rd("a192_rk12", 4'd12, 1'b1, 128'he98ba06f448c773c8ecc720401002202, 1'b0);

    // Read and restart (AES-256) on the same edge.
    rk_req   = 1'b1;
    rk_idx   = 4'd12;
    start    = 1'b1;
    key_size = 2'd2;
    key_in   = K256;
    tick();
    rk_req   = 1'b0;
    start    = 1'b0;
    chk("rr_valid", rk_valid, 1);
    chk("rr_data", rk_data, 128'he98ba06f448c773c8ecc720401002202);
    chk("rr_busy", busy, 1);
    chk("rr_ready", ready, 0);
    wait_done("lat256", 53, 1'b0);
    chk("a256_nr", nr, 14);
    rd("a256_rk1", 4'd1, 1'b1, 128'h1f352c073b6108d72d9810a30914dff4, 1'b0);
    rd("a256_rk3", 4'd3, 1'b1, 128'ha8b09c1a93d194cdbe49846eb75d5b9a, 1'b0);
    rd("a256_rk14", 4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e, 1'b0);

    // Reset mid-expansion, then a fresh AES-128 run.
    begin_run(2'd2, K256);
    seen_done = 1'b0;
    repeat (19) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_nr", nr, 0);
    chk("mid_rst_no_done", seen_done, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_done", done, 0);
    begin_run(2'd0, K128);
    wait_done("lat128_again", 41, 1'b0);
    rd("again_rk1", 4'd1, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0);
    rd("again_rk10", 4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_key_schedule_ctrl.md
Name: aes_key_schedule_ctrl

Overview:
- Sequential AES key-schedule controller that replaces fully-combinational, event-triggered key expansion with a one-word-per-cycle iterative engine.
- Supports AES-128/192/256, selected at run time.
- Stores the full expanded schedule in an internal word buffer.
- Serves 128-bit round keys to the cipher round engine through a registered request/valid read port.
- Sits between the key-load interface and the round datapath.

Parameters:
- MAX_NK, 8, maximum key length in 32-bit words; sets key_in width.
- NB, 4, block size in words; fixed by AES.
- MAX_WORDS, 60, buffer depth, equal to NB*(14+1).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a new expansion; sampled only in IDLE or READY.
- key_size  in  2  key size: 0 = 128-bit, 1 = 192-bit, 2 = 256-bit, 3 = illegal.
- key_in  in  32*MAX_NK  cipher key, left-aligned.
  - Word 0 = key_in[255:224].
  - AES-128 uses [255:128]; AES-192 uses [255:64]; unused low bits ignored.
- busy  out  1  high in LOAD and EXPAND.
- done  out  1  one-cycle pulse when the schedule is complete.
- ready  out  1  level; schedule valid and readable.
- nr  out  4  round count of the stored schedule (10/12/14); 0 when not ready.
- err  out  1  one-cycle pulse on an illegal start or an illegal read.
- rk_req  in  1  round-key read request.
- rk_idx  in  4  round-key index, 0..nr.
- rk_valid  out  1  read response valid.
- rk_data  out  128  round key {w[4k], w[4k+1], w[4k+2], w[4k+3]}.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - busy, done, ready, err, rk_valid = 0; nr = 0; rk_data = 0.
  - Rcon register = 8'h01; word counter = 0.
  - Buffer contents need not be cleared, but are unreadable until ready=1.
- FSM states: IDLE, LOAD, EXPAND, READY.
- IDLE/READY with start=1 and key_size!=3:
  - Latch key_size, derive NK (4/6/8) and NR (10/12/14).
  - Go to LOAD; ready and nr drop to 0 on the same edge.
- start with key_size=3: ignored; err pulses 1 cycle; state unchanged (READY stays READY with the old schedule).
- LOAD (1 cycle): write w[0..NK-1] from key_in; counter i = NK; go to EXPAND.
- EXPAND: write exactly one word per cycle, w[i] = w[i-NK] ^ temp, where temp = w[i-1] transformed as follows:
  - i%NK==0: temp = SubWord(RotWord(w[i-1])) ^ {Rcon, 24'h0}; then Rcon = xtime(Rcon).
  - Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - NK==8 and i%NK==4: temp = SubWord(w[i-1]).
  - Otherwise: temp = w[i-1].
- Expansion length:
  - Last word index is 4*(NR+1)-1: 43, 51 or 59.
  - After writing the last word go to READY; done=1 and ready=1 in the first READY cycle.
- Latency, from the edge that samples start to the first cycle with done=1:
  - 1 + 4*(NR+1) - NK cycles, i.e. 41 (AES-128), 47 (AES-192), 53 (AES-256).
- start while busy: ignored; no err.
- SubWord: one 4-byte S-box lookup per cycle, combinational within the EXPAND cycle.
- Read port:
  - rk_req=1, ready=1, rk_idx<=nr: next cycle rk_valid=1 and rk_data = round key rk_idx.
  - Reads are back-to-back capable, one per cycle.
  - rk_req with rk_idx>nr: next cycle rk_valid=0, err=1.
  - rk_req while not ready: no response, no err.
  - rk_valid low otherwise; rk_data holds its last value.
- Read and restart in the same cycle: the read is served (old schedule); start is also accepted.
- Reset mid-EXPAND: immediate return to IDLE. No done, no ready, and Rcon restarts at 01 on the next start.

Test Plan:
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, key_size=0 -> done at cycle 41; nr=10; rk_idx=1 gives a0fafe1788542cb123a339392a6c7605; rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, key_size=1 -> done at cycle 47; nr=12; rk_idx=12 gives e98ba06f448c773c8ecc720401002202.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, key_size=2 -> done at cycle 53; rk_idx=14 gives fe4890d1e6188d0b046df344706c631e.
- In READY after AES-128: start with key_size=3 -> err pulse; ready stays 1; rk_idx=10 still returns d014f9a8...; then rk_idx=11 -> err pulse, no rk_valid.
- Start AES-256, pulse rst low at cycle 20, then start AES-128 -> no done from the first run; AES-128 round keys match vector 1 (Rcon restarted).
- Second start issued during busy plus rk_req during busy -> both ignored; done arrives at the original latency with the original key's schedule.
